execute_stage: RTL and testbench



---
 rtl/execute_stage.sv | 178 +++++++++++++++++
 tb/tb_execute_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage: forwarding, ALU, branch resolution, EX/MEM register; optional MAC scratch unit (MAC_UNIT_EN).
// One-cycle latency; stall_i holds all state, flush_i squashes the entering instruction (flush wins over stall).
module execute_stage #(
  parameter int DATA_W    = 32,
  parameter int MAC_DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic [DATA_W-1:0] read_data1_i,
  input  logic [DATA_W-1:0] read_data2_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [DATA_W-1:0] forward_data_i,
  input  logic [1:0]        forward_en_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [3:0]        alu_op_i,
  input  logic              imm_sel_i,
  input  logic [1:0]        branch_type_i,
  input  logic [1:0]        wb_sel_i,
  input  logic              reg_write_enable_i,
  input  logic              mem_write_enable_i,
  input  logic              mem_cache_valid_i,
  input  logic [4:0]        reg_write_dst_i,
  input  logic [4:0]        row_i,
  input  logic [4:0]        col_i,
  input  logic              start_i,
  input  logic              write_enable_A_i,
  input  logic              write_enable_B_i,
  input  logic              write_enable_C_i,
  output logic [DATA_W-1:0] result_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] cout_o,
  output logic [DATA_W-1:0] read_data2_o,
  output logic [1:0]        wb_sel_o,
  output logic              reg_write_enable_o,
  output logic              mem_write_enable_o,
  output logic              mem_cache_valid_o,
  output logic [4:0]        reg_write_dst_o,
  output logic [1:0]        branch_inst_o,
  output logic              branch_dec_o,
  output logic [4:0]        e_dest_reg_o,
  output logic              e_valid_o
);

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_r2;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu;
  logic [DATA_W-1:0] target;
  logic [DATA_W-1:0] next_pc;
  logic              taken;

  assign op_a  = forward_en_i[0] ? forward_data_i : read_data1_i;
  assign op_r2 = forward_en_i[1] ? forward_data_i : read_data2_i;
  assign op_b  = imm_sel_i ? imm_i : op_r2;

  assign e_dest_reg_o = reg_write_dst_i;
  assign e_valid_o    = reg_write_enable_i & ~flush_i;

  always_comb begin
    alu = '0;
    case (alu_op_i)
      4'b0001: alu = op_a + op_b;
      4'b0010: alu = op_a - op_b;
      4'b0011: alu = op_a ^ op_b;
      4'b0100: alu = op_a | op_b;
      4'b0101: alu = op_a & op_b;
      4'b0110: alu = op_a << op_b[4:0];
      4'b0111: alu = op_a >> op_b[4:0];
      4'b1000: alu = $signed(op_a) >>> op_b[4:0];
      4'b1001: alu = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'b1010: alu = op_a * op_b;
      4'b1011: alu = op_b << 12;
      default: alu = '0;
    endcase
  end

  always_comb begin
    taken  = 1'b0;
    target = pc_i + imm_i;
    case (branch_type_i)
      2'b01: begin
        case (alu_op_i)
          4'b1100: taken = (op_a == op_b);
          4'b1101: taken = (op_a != op_b);
          4'b1110: taken = ($signed(op_a) > $signed(op_b));
          4'b1111: taken = ($signed(op_a) < $signed(op_b));
          default: taken = 1'b0;
        endcase
      end
      2'b10: taken = 1'b1;
      2'b11: begin
        taken  = 1'b1;
        target = op_a;
      end
      default: taken = 1'b0;
    endcase
  end

  assign next_pc = taken ? target : pc_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      result_o           <= '0;
      pc_o               <= '0;
      read_data2_o       <= '0;
      wb_sel_o           <= '0;
      reg_write_enable_o <= 1'b0;
      mem_write_enable_o <= 1'b0;
      mem_cache_valid_o  <= 1'b0;
      reg_write_dst_o    <= '0;
      branch_inst_o      <= '0;
      branch_dec_o       <= 1'b0;
    end else if (flush_i) begin
      // Squashed slot keeps its PC so a redirect can restart from it.
      result_o           <= '0;
      pc_o               <= pc_i;
      read_data2_o       <= op_r2;
      wb_sel_o           <= wb_sel_i;
      reg_write_enable_o <= 1'b0;
      mem_write_enable_o <= 1'b0;
      mem_cache_valid_o  <= 1'b0;
      reg_write_dst_o    <= reg_write_dst_i;
      branch_inst_o      <= '0;
      branch_dec_o       <= 1'b0;
    end else if (!stall_i) begin
      result_o           <= alu;
      pc_o               <= next_pc;
      read_data2_o       <= op_r2;
      wb_sel_o           <= wb_sel_i;
      reg_write_enable_o <= reg_write_enable_i;
      mem_write_enable_o <= mem_write_enable_i;
      mem_cache_valid_o  <= mem_cache_valid_i;
      reg_write_dst_o    <= reg_write_dst_i;
      branch_inst_o      <= branch_type_i;
      branch_dec_o       <= taken;
    end
  end

`ifdef MAC_UNIT_EN
  localparam int IDX_W = $clog2(MAC_DEPTH);

  logic [DATA_W-1:0] abank [MAC_DEPTH];
  logic [DATA_W-1:0] bbank [MAC_DEPTH];
  logic [DATA_W-1:0] acc;
  logic [IDX_W-1:0]  row_idx;
  logic [IDX_W-1:0]  col_idx;
  logic              unused_idx;

  assign row_idx    = row_i[IDX_W-1:0];
  assign col_idx    = col_i[IDX_W-1:0];
  assign unused_idx = ^{row_i, col_i};
  assign cout_o     = acc;

  // Flush squashes the instruction, not the scratch unit, so MAC only advances on a clean slot.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < MAC_DEPTH; i++) begin
        abank[i] <= '0;
        bbank[i] <= '0;
      end
      acc <= '0;
    end else if (!flush_i && !stall_i) begin
      if (write_enable_A_i) abank[row_idx] <= op_a;
      if (write_enable_B_i) bbank[col_idx] <= op_r2;
      if (write_enable_C_i)  acc <= '0;
      else if (start_i)      acc <= acc + abank[row_idx] * bbank[col_idx];
    end
  end
`else
  logic unused_mac;

  assign unused_mac = ^{row_i, col_i, start_i, write_enable_A_i, write_enable_B_i, write_enable_C_i};
  assign cout_o     = '0;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Directed plus randomized bench for execute_stage against an arithmetic reference model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, stall;
  logic [31:0] rd1, rd2, imm, fwd, pc;
  logic [1:0]  fwd_en;
  logic [3:0]  alu_op;
  logic        imm_sel;
  logic [1:0]  br_type;
  logic [1:0]  wb_sel;
  logic        reg_we, mem_we, mem_cv;
  logic [4:0]  dst, row, col;
  logic        start, we_a, we_b, we_c;

  logic [31:0] result_o, pc_o, cout_o, read_data2_o;
  logic [1:0]  wb_sel_o, branch_inst_o;
  logic        reg_write_enable_o, mem_write_enable_o, mem_cache_valid_o, branch_dec_o;
  logic [4:0]  reg_write_dst_o, e_dest_reg_o;
  logic        e_valid_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] x_result, x_pc, x_rd2, x_acc;
  logic [1:0]  x_wb, x_bi;
  logic        x_rwe, x_mwe, x_mcv, x_bd;
  logic [4:0]  x_dst;
  logic [31:0] ma [8];
  logic [31:0] mb [8];

  execute_stage dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .stall_i(stall),
    .read_data1_i(rd1), .read_data2_i(rd2), .imm_i(imm), .forward_data_i(fwd),
    .forward_en_i(fwd_en), .pc_i(pc), .alu_op_i(alu_op), .imm_sel_i(imm_sel),
    .branch_type_i(br_type), .wb_sel_i(wb_sel), .reg_write_enable_i(reg_we),
    .mem_write_enable_i(mem_we), .mem_cache_valid_i(mem_cv), .reg_write_dst_i(dst),
    .row_i(row), .col_i(col), .start_i(start), .write_enable_A_i(we_a),
    .write_enable_B_i(we_b), .write_enable_C_i(we_c),
    .result_o(result_o), .pc_o(pc_o), .cout_o(cout_o), .read_data2_o(read_data2_o),
    .wb_sel_o(wb_sel_o), .reg_write_enable_o(reg_write_enable_o),
    .mem_write_enable_o(mem_write_enable_o), .mem_cache_valid_o(mem_cache_valid_o),
    .reg_write_dst_o(reg_write_dst_o), .branch_inst_o(branch_inst_o),
    .branch_dec_o(branch_dec_o), .e_dest_reg_o(e_dest_reg_o), .e_valid_o(e_valid_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input int a, input int b, input logic [3:0] op);
    longint      p;
    int          sh;
    logic [31:0] ua;
    sh = b & 31;
    ua = a;
    case (op)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a ^ b;
      4'd4:    return a | b;
      4'd5:    return a & b;
      4'd6:    return a << sh;
      4'd7:    return ua >> sh;
      4'd8:    return a >>> sh;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      4'd10: begin
        p = longint'(a) * longint'(b);
        return p[31:0];
      end
      4'd11:   return b * 4096;
      default: return 32'd0;
    endcase
  endfunction

  task automatic clear_inputs();
    flush = 0; stall = 0; rd1 = 0; rd2 = 0; imm = 0; fwd = 0; pc = 0; fwd_en = 0;
    alu_op = 0; imm_sel = 0; br_type = 0; wb_sel = 0; reg_we = 0; mem_we = 0; mem_cv = 0;
    dst = 0; row = 0; col = 0; start = 0; we_a = 0; we_b = 0; we_c = 0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".result"}, result_o, x_result);
    check({tag, ".pc"}, pc_o, x_pc);
    check({tag, ".rd2"}, read_data2_o, x_rd2);
    check({tag, ".wb_sel"}, 32'(wb_sel_o), 32'(x_wb));
    check({tag, ".rwe"}, 32'(reg_write_enable_o), 32'(x_rwe));
    check({tag, ".mwe"}, 32'(mem_write_enable_o), 32'(x_mwe));
    check({tag, ".mcv"}, 32'(mem_cache_valid_o), 32'(x_mcv));
    check({tag, ".dst"}, 32'(reg_write_dst_o), 32'(x_dst));
    check({tag, ".br_inst"}, 32'(branch_inst_o), 32'(x_bi));
    check({tag, ".br_dec"}, 32'(branch_dec_o), 32'(x_bd));
`ifdef MAC_UNIT_EN
    check({tag, ".cout"}, cout_o, x_acc);
`else
    check({tag, ".cout"}, cout_o, 32'd0);
`endif
  endtask

  // Applies current inputs for one edge, predicting the registered state from first principles.
  task automatic step(input string tag);
    int          a, r2, b;
    logic        tk;
    logic [31:0] tgt, prod;
    #1;
    check({tag, ".e_dest"}, 32'(e_dest_reg_o), 32'(dst));
    check({tag, ".e_valid"}, 32'(e_valid_o), 32'(reg_we && !flush));
    a  = fwd_en[0] ? fwd : rd1;
    r2 = fwd_en[1] ? fwd : rd2;
    b  = imm_sel ? imm : r2;
    tk = 0;
    tgt = pc + imm;
    if (br_type == 2'd1) begin
      if (alu_op == 4'd12) tk = (a == b);
      if (alu_op == 4'd13) tk = (a != b);
      if (alu_op == 4'd14) tk = (a > b);
      if (alu_op == 4'd15) tk = (a < b);
    end else if (br_type == 2'd2) begin
      tk = 1;
    end else if (br_type == 2'd3) begin
      tk = 1;
      tgt = a;
    end
    if (flush) begin
      x_result = 0; x_pc = pc; x_rd2 = r2; x_wb = wb_sel; x_dst = dst;
      x_rwe = 0; x_mwe = 0; x_mcv = 0; x_bi = 0; x_bd = 0;
    end else if (!stall) begin
      x_result = alu_ref(a, b, alu_op); x_pc = tk ? tgt : pc; x_rd2 = r2; x_wb = wb_sel;
      x_dst = dst; x_rwe = reg_we; x_mwe = mem_we; x_mcv = mem_cv; x_bi = br_type; x_bd = tk;
      prod = ma[row % 8] * mb[col % 8];
      if (we_c) x_acc = 0;
      else if (start) x_acc = x_acc + prod;
      if (we_a) ma[row % 8] = a;
      if (we_b) mb[col % 8] = r2;
    end
    @(posedge clk);
    #1;
    check_regs(tag);
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    x_result = 0; x_pc = 0; x_rd2 = 0; x_acc = 0; x_wb = 0; x_bi = 0;
    x_rwe = 0; x_mwe = 0; x_mcv = 0; x_bd = 0; x_dst = 0;
    for (int i = 0; i < 8; i++) begin ma[i] = 0; mb[i] = 0; end
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset");
    rst_n = 1;
    #2;
    check_regs("reset_release");

    rd1 = 7; imm = -3; imm_sel = 1; alu_op = 4'd1; reg_we = 1; dst = 5'd3;
    step("add_imm");
    check("add_imm_direct", result_o, 32'd4);

    rd1 = 32'h8000_0000; rd2 = 4; alu_op = 4'd8;
    step("sra");
    check("sra_direct", result_o, 32'hF800_0000);

    rd2 = 1; alu_op = 4'd11;
    step("lui");
    check("lui_direct", result_o, 32'h0000_1000);

    pc = 32'h100; imm = 32'h20; br_type = 2'd1; alu_op = 4'd12; rd1 = 5; rd2 = 5;
    step("beq_taken");
    check("beq_taken_pc", pc_o, 32'h120);
    check("beq_taken_dec", 32'(branch_dec_o), 32'd1);

    pc = 32'h100; imm = 32'h20; br_type = 2'd1; alu_op = 4'd12; rd1 = 5; rd2 = 6;
    step("beq_not");
    check("beq_not_pc", pc_o, 32'h100);

    pc = 32'h100; imm = 32'h20; br_type = 2'd3; rd1 = 32'h400;
    step("jr");
    check("jr_pc", pc_o, 32'h400);

    fwd_en = 2'b01; fwd = 10; rd1 = 1; rd2 = 2; alu_op = 4'd1; mem_we = 1; mem_cv = 1;
    step("fwd_a");
    check("fwd_a_direct", result_o, 32'd12);

    stall = 1; rd1 = 99; rd2 = 77; alu_op = 4'd2; pc = 32'h500; br_type = 2'd2; reg_we = 0;
    step("stall");
    check("stall_result_held", result_o, 32'd12);

    flush = 1; stall = 1; br_type = 2'd2; pc = 32'h600; imm = 32'h40; reg_we = 1; mem_we = 1;
    step("flush");
    check("flush_pc", pc_o, 32'h600);
    check("flush_rwe", 32'(reg_write_enable_o), 32'd0);

    we_c = 1;
    step("mac_clear");
    rd1 = 3; rd2 = 4; we_a = 1; we_b = 1;
    step("mac_write");
    start = 1;
    step("mac_start1");
    start = 1;
    step("mac_start2");
`ifdef MAC_UNIT_EN
    check("mac_24", cout_o, 32'd24);
`else
    check("mac_off", cout_o, 32'd0);
`endif

    for (int n = 0; n < 400; n++) begin
      rd1 = $urandom; rd2 = $urandom; fwd = $urandom; pc = $urandom;
      imm = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 64));
      fwd_en = 2'($urandom_range(0, 3)); alu_op = 4'($urandom_range(0, 15));
      imm_sel = 1'($urandom_range(0, 1)); br_type = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) rd2 = rd1;
      wb_sel = 2'($urandom_range(0, 3)); reg_we = 1'($urandom_range(0, 1));
      mem_we = 1'($urandom_range(0, 1)); mem_cv = 1'($urandom_range(0, 1));
      dst = 5'($urandom_range(0, 31)); row = 5'($urandom_range(0, 31));
      col = 5'($urandom_range(0, 31)); start = 1'($urandom_range(0, 1));
      we_a = 1'($urandom_range(0, 1)); we_b = 1'($urandom_range(0, 1));
      we_c = ($urandom_range(0, 15) == 0); stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
